// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory requester.
package mem_access_ctrl_pkg;
    localparam int DEPTH_DEF = 64;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;
endpackage

// File: rtl/mem_access_ctrl_lane_mux.sv
// Big-endian lane extract (with sign/zero extension) for loads and lane merge for stores.
module lane_mux
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] merged
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[7:0];
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];

        case (size)
            SZ_BYTE: ldata = {{24{~uns & b[7]}}, b};
            SZ_HALF: ldata = {{16{~uns & h[15]}}, h};
            default: ldata = word;
        endcase

        merged = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    merged[31:24] = wdata[7:0];
                    2'd1:    merged[23:16] = wdata[7:0];
                    2'd2:    merged[15:8]  = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) merged[15:0]  = wdata[15:0];
                else        merged[31:16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory requester: sub-word loads, read-modify-write sub-word stores,
// alignment/range faults, one-cycle stall while the merged word is written back.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          m_req,
    input  logic          m_wmem,
    input  logic [1:0]    m_size,
    input  logic          m_unsigned,
    input  logic [31:0]   m_addr,
    input  logic [31:0]   m_wdata,
    output logic          m_stall,
    output logic [31:0]   m_rdata,
    output logic          m_rvalid,
    output logic          m_fault,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    output logic          dm_we,
    input  logic [31:0]   dm_rdata
);
    state_t        state_q, state_d;
    logic [31:0]   ldata, merged, merged_q;
    logic [AW-1:0] idx_q;
    logic          fault, acc, idle;

    // Faults are decided purely from the request, so a faulting store never writes.
    assign fault = (m_size == 2'b11)
                 | ((m_size == SZ_HALF) & m_addr[0])
                 | ((m_size == SZ_WORD) & (m_addr[1:0] != 2'b00))
                 | (m_addr[31:2] >= 30'(DEPTH));
    assign idle  = (state_q == IDLE);
    assign acc   = idle & m_req & ~fault;

    lane_mux u_lane (
        .word   (dm_rdata),
        .off    (m_addr[1:0]),
        .size   (m_size),
        .uns    (m_unsigned),
        .wdata  (m_wdata),
        .ldata  (ldata),
        .merged (merged)
    );

    always_comb begin
        state_d  = state_q;
        m_stall  = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = m_addr[AW+1:2];
        dm_wdata = m_wdata;
        case (state_q)
            IDLE: begin
                dm_we = acc & m_wmem & (m_size == SZ_WORD);
                if (acc && m_wmem && (m_size != SZ_WORD)) state_d = RMW_WR;
            end
            RMW_WR: begin
                m_stall  = 1'b1;
                dm_we    = 1'b1;
                dm_addr  = idx_q;
                dm_wdata = merged_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            m_rdata  <= '0;
            m_rvalid <= 1'b0;
            m_fault  <= 1'b0;
            merged_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            m_rvalid <= acc & ~m_wmem;
            m_fault  <= idle & m_req & fault;
            if (acc && !m_wmem) m_rdata <= ldata;
            if (acc && m_wmem && (m_size != SZ_WORD)) begin
                merged_q <= merged;
                idx_q    <= m_addr[AW+1:2];
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a word-wide memory model (comb read, negedge write).
module tb_mem_access_ctrl;
    logic        clock, resetn;
    logic        m_req, m_wmem, m_unsigned;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_stall, m_rvalid, m_fault, dm_we;
    logic [31:0] m_rdata, dm_wdata, dm_rdata;
    logic [5:0]  dm_addr;
    logic [31:0] mem [64];

    int tests = 0;
    int fails = 0;

    mem_access_ctrl #(.DEPTH(64), .AW(6)) dut (
        .clock(clock), .resetn(resetn), .m_req(m_req), .m_wmem(m_wmem),
        .m_size(m_size), .m_unsigned(m_unsigned), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_stall(m_stall), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_fault(m_fault),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign dm_rdata = mem[dm_addr];
    always @(negedge clock) if (dm_we) mem[dm_addr] <= dm_wdata;

    task automatic set_req(input logic req, input logic wm, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] d);
        m_req = req; m_wmem = wm; m_size = sz; m_unsigned = uns; m_addr = a; m_wdata = d;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        #12;
        tests++; if (m_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b want 0", m_rvalid); end
        tests++; if (m_fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b want 0", m_fault); end
        tests++; if (m_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", m_rdata); end
        tests++; if (m_stall !== 1'b0 || dm_we !== 1'b0) begin fails++; $display("FAIL reset_stall_we got %b%b want 00", m_stall, dm_we); end
        @(negedge clock);
        resetn = 1'b1;
        step();
    endtask

    task automatic test_load_word();
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        #1;
        tests++; if (dm_addr !== 6'd1 || dm_we !== 1'b0 || m_stall !== 1'b0) begin fails++;
            $display("FAIL lw_comb addr=%0d we=%b stall=%b want 1 0 0", dm_addr, dm_we, m_stall); end
        step();
        tests++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h10000011) begin fails++;
            $display("FAIL lw_data rvalid=%b rdata=%h want 1 10000011", m_rvalid, m_rdata); end
        set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        step();
        tests++; if (m_rvalid !== 1'b0 || m_fault !== 1'b0) begin fails++;
            $display("FAIL idle_pulses rvalid=%b fault=%b want 0 0", m_rvalid, m_fault); end
    endtask

    task automatic test_subword_loads();
        logic [1:0]  sz  [5];
        logic        un  [5];
        logic [31:0] ad  [5];
        logic [31:0] exp [5];
        sz = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
        un = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ad = '{32'h0, 32'h0, 32'h2, 32'h3, 32'h0};
        exp = '{32'hFFFFFFA0, 32'h000000A0, 32'h000000AA, 32'hFFFFFFAA, 32'hFFFFA000};
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 1'b0, sz[i], un[i], ad[i], 32'h0);
            step();
            tests++; if (m_rvalid !== 1'b1 || m_rdata !== exp[i]) begin fails++;
                $display("FAIL subload_%0d rvalid=%b rdata=%h want 1 %h", i, m_rvalid, m_rdata, exp[i]); end
        end
        set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_rmw_store();
        set_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h7, 32'h000000FF);
        #1;
        tests++; if (dm_we !== 1'b0 || m_stall !== 1'b0) begin fails++;
            $display("FAIL sb_cycle0 we=%b stall=%b want 0 0", dm_we, m_stall); end
        step();
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        #1;
        tests++; if (dm_we !== 1'b1 || m_stall !== 1'b1 || dm_wdata !== 32'h100000FF || dm_addr !== 6'd1) begin fails++;
            $display("FAIL sb_rmw we=%b stall=%b wdata=%h addr=%0d want 1 1 100000ff 1", dm_we, m_stall, dm_wdata, dm_addr); end
        step();
        tests++; if (m_rvalid !== 1'b0) begin fails++; $display("FAIL stalled_lw rvalid=%b want 0", m_rvalid); end
        tests++; if (m_stall !== 1'b0 || dm_we !== 1'b0) begin fails++;
            $display("FAIL after_rmw stall=%b we=%b want 0 0", m_stall, dm_we); end
        step();
        tests++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h100000FF) begin fails++;
            $display("FAIL rmw_readback rvalid=%b rdata=%h want 1 100000ff", m_rvalid, m_rdata); end
        set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_faults();
        set_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h1, 32'h0);
        #1;
        tests++; if (dm_we !== 1'b0 || m_stall !== 1'b0) begin fails++;
            $display("FAIL lh_mis_comb we=%b stall=%b want 0 0", dm_we, m_stall); end
        step();
        tests++; if (m_fault !== 1'b1 || m_rvalid !== 1'b0) begin fails++;
            $display("FAIL lh_mis fault=%b rvalid=%b want 1 0", m_fault, m_rvalid); end
        set_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        #1;
        tests++; if (dm_we !== 1'b0 || m_stall !== 1'b0) begin fails++;
            $display("FAIL sw_range_comb we=%b stall=%b want 0 0", dm_we, m_stall); end
        step();
        tests++; if (m_fault !== 1'b1) begin fails++; $display("FAIL sw_range fault=%b want 1", m_fault); end
        set_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
        step();
        tests++; if (m_fault !== 1'b1 || m_rvalid !== 1'b0) begin fails++;
            $display("FAIL size11 fault=%b rvalid=%b want 1 0", m_fault, m_rvalid); end
        set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        step();
        tests++; if (m_fault !== 1'b0) begin fails++; $display("FAIL fault_clear fault=%b want 0", m_fault); end
        tests++; if (mem[0] !== 32'hA00000AA || mem[1] !== 32'h100000FF) begin fails++;
            $display("FAIL fault_nowrite mem0=%h mem1=%h want a00000aa 100000ff", mem[0], mem[1]); end
    endtask

    task automatic test_back_to_back();
        set_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678);
        #1;
        tests++; if (dm_we !== 1'b1 || m_stall !== 1'b0 || dm_wdata !== 32'h12345678) begin fails++;
            $display("FAIL sw_comb we=%b stall=%b wdata=%h want 1 0 12345678", dm_we, m_stall, dm_wdata); end
        step();
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        #1;
        tests++; if (m_stall !== 1'b0) begin fails++; $display("FAIL b2b_stall stall=%b want 0", m_stall); end
        step();
        tests++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h12345678) begin fails++;
            $display("FAIL b2b_lw rvalid=%b rdata=%h want 1 12345678", m_rvalid, m_rdata); end
        set_req(1'b1, 1'b1, 2'b01, 1'b0, 32'hA, 32'h0000BEEF);
        step();
        step();
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        step();
        tests++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h1234BEEF) begin fails++;
            $display("FAIL sh_lo rvalid=%b rdata=%h want 1 1234beef", m_rvalid, m_rdata); end
        set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_reset_mid_rmw();
        set_req(1'b1, 1'b1, 2'b01, 1'b0, 32'h0, 32'h0000BEEF);
        step();
        set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        tests++; if (dm_we !== 1'b1) begin fails++; $display("FAIL sh_rmw_we we=%b want 1", dm_we); end
        resetn = 1'b0;
        #1;
        tests++; if (dm_we !== 1'b0 || m_stall !== 1'b0 || m_rvalid !== 1'b0 || m_fault !== 1'b0 || m_rdata !== 32'h0) begin fails++;
            $display("FAIL rst_mid we=%b stall=%b rvalid=%b fault=%b rdata=%h want all 0",
                     dm_we, m_stall, m_rvalid, m_fault, m_rdata); end
        @(negedge clock); #1;
        tests++; if (mem[0] !== 32'hA00000AA) begin fails++; $display("FAIL rst_nowrite mem0=%h want a00000aa", mem[0]); end
        resetn = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'hA00000AA;
        mem[1] = 32'h10000011;
        test_reset();
        test_load_word();
        test_subword_loads();
        test_rmw_store();
        test_faults();
        test_back_to_back();
        test_reset_mid_rmw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
